// File: rtl/spi_target_pkg.sv
// Shared constants for the SPI target: register map, status/interrupt bit
// positions and the frame state encoding.
package spi_target_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_RXDATA = 3'd2;
    localparam logic [2:0] REG_TXDATA = 3'd3;
    localparam logic [2:0] REG_INTREQ = 3'd4;
    localparam logic [2:0] REG_INTENA = 3'd5;
    localparam logic [2:0] REG_INTACT = 3'd6;
    localparam logic [2:0] REG_FILL   = 3'd7;

    localparam int unsigned ST_RX_EMPTY  = 0;
    localparam int unsigned ST_RX_FULL   = 1;
    localparam int unsigned ST_TX_EMPTY  = 2;
    localparam int unsigned ST_TX_FULL   = 3;
    localparam int unsigned ST_SS_ACTIVE = 4;
    localparam int unsigned ST_OVERRUN   = 5;
    localparam int unsigned ST_UNDERRUN  = 6;

    localparam int unsigned IR_RX_AVAIL  = 0;
    localparam int unsigned IR_FRAME_END = 1;
    localparam int unsigned IR_OVERRUN   = 2;
    localparam int unsigned IR_UNDERRUN  = 3;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_target_sync_fifo.sv
// Show-ahead synchronous FIFO; a pop frees room for a same-cycle push when full.
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == CNT_W'(0));
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target with CPU register interface, RX/TX byte FIFOs and
// sticky interrupt sources.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  FILL_RESET = 8'hFF
) (
    input  logic              C100M,
    input  logic              reset,
    input  logic [23:1]       ADDR,
    input  logic              access,
    input  logic              RW,
    input  logic              ds_n,
    output logic              dtack_n,
    output logic              data_oe,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              INT2_n,
    input  logic              SS_n,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_oe
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [2:0] wr_sync, rd_sync, ss_sync, sclk_sync, mosi_sync;
    logic       wr_strobe, rd_strobe;
    logic       ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_bit, ss_active;
    logic [2:0] reg_sel;
    logic       addr_hi_unused;

    logic              enable_q;
    logic [BYTE_W-1:0] fill_q;
    logic [DATA_W-1:0] intena_q;
    logic              underrun_q, overrun_q, frame_end_q;

    spi_state_t        state_q, state_d;
    logic [2:0]        bit_cnt_q;
    logic [BYTE_W-1:0] rx_shift_q, tx_shift_q, rx_next;
    logic              tx_load_c, rx_push_c, rx_shift_c, tx_shift_c, frame_end_c;

    logic              rx_pop, rx_full, rx_empty;
    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic [BYTE_W-1:0] rx_head, tx_head;
    logic [CNT_W-1:0]  rx_count_unused, tx_count_unused;

    logic [DATA_W-1:0] status, intreq, intact, rd_data_c;
    logic [IR_UNDERRUN:IR_FRAME_END] intreq_clr;

    assign dtack_n        = ~access;
    assign data_oe        = access & ~ds_n & RW;
    assign reg_sel        = ADDR[3:1];
    assign addr_hi_unused = ^ADDR[23:4];
    assign MISO           = tx_shift_q[7];

    // Bus access and SPI pins are asynchronous to C100M
    always_ff @(posedge C100M) begin
        if (reset) begin
            wr_sync   <= '0;
            rd_sync   <= '0;
            ss_sync   <= 3'b111;
            sclk_sync <= '0;
            mosi_sync <= '0;
        end else begin
            wr_sync   <= {wr_sync[1:0], access & ~ds_n & ~RW};
            rd_sync   <= {rd_sync[1:0], access & ~ds_n & RW};
            ss_sync   <= {ss_sync[1:0], SS_n};
            sclk_sync <= {sclk_sync[1:0], SCLK};
            mosi_sync <= {mosi_sync[1:0], MOSI};
        end
    end

    assign wr_strobe = (wr_sync[2:1] == 2'b01);
    assign rd_strobe = (rd_sync[2:1] == 2'b01);
    assign ss_fall   = (ss_sync[2:1] == 2'b10);
    assign ss_rise   = (ss_sync[2:1] == 2'b01);
    assign sclk_rise = (sclk_sync[2:1] == 2'b01);
    assign sclk_fall = (sclk_sync[2:1] == 2'b10);
    assign mosi_bit  = mosi_sync[2];
    assign ss_active = ~ss_sync[2];
    assign rx_next   = {rx_shift_q[6:0], mosi_bit};

    assign tx_push    = wr_strobe && (reg_sel == REG_TXDATA) && !tx_full;
    assign rx_pop     = rd_strobe && (reg_sel == REG_RXDATA) && !rx_empty;
    assign tx_pop     = tx_load_c & ~tx_empty;
    assign intreq_clr = (wr_strobe && (reg_sel == REG_INTREQ)) ? data_in[IR_UNDERRUN:IR_FRAME_END] : '0;

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(BYTE_W)) u_rx_fifo (
        .clk       (C100M),
        .reset     (reset),
        .push      (rx_push_c),
        .push_data (rx_next),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count_unused)
    );

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(BYTE_W)) u_tx_fifo (
        .clk       (C100M),
        .reset     (reset),
        .push      (tx_push),
        .push_data (data_in[BYTE_W-1:0]),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count_unused)
    );

    // Frame state: next state and per-cycle shift/load controls
    always_comb begin
        state_d     = state_q;
        tx_load_c   = 1'b0;
        rx_push_c   = 1'b0;
        rx_shift_c  = 1'b0;
        tx_shift_c  = 1'b0;
        frame_end_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ss_fall && enable_q) begin
                    state_d   = S_ACTIVE;
                    tx_load_c = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (ss_rise || !enable_q) begin
                    state_d     = S_IDLE;
                    frame_end_c = ss_rise;
                end else if (sclk_rise) begin
                    rx_shift_c = 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_push_c = 1'b1;
                        tx_load_c = 1'b1;
                    end
                end else if (sclk_fall && (bit_cnt_q != 3'd0)) begin
                    tx_shift_c = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge C100M) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= 8'hFF;
        end else begin
            state_q <= state_d;
            if (rx_shift_c) begin
                bit_cnt_q  <= bit_cnt_q + 3'd1;
                rx_shift_q <= rx_next;
            end else if (state_q == S_IDLE || state_d == S_IDLE) begin
                bit_cnt_q <= '0;
            end
            if (tx_load_c) begin
                tx_shift_q <= tx_empty ? fill_q : tx_head;
            end else if (tx_shift_c) begin
                tx_shift_q <= {tx_shift_q[6:0], 1'b0};
            end
        end
    end

    always_comb begin
        status               = '0;
        status[ST_RX_EMPTY]  = rx_empty;
        status[ST_RX_FULL]   = rx_full;
        status[ST_TX_EMPTY]  = tx_empty;
        status[ST_TX_FULL]   = tx_full;
        status[ST_SS_ACTIVE] = ss_active;
        status[ST_OVERRUN]   = overrun_q;
        status[ST_UNDERRUN]  = underrun_q;
        intreq               = '0;
        intreq[IR_RX_AVAIL]  = ~rx_empty;
        intreq[IR_FRAME_END] = frame_end_q;
        intreq[IR_OVERRUN]   = overrun_q;
        intreq[IR_UNDERRUN]  = underrun_q;
        intact               = intreq & intena_q;
    end

    always_comb begin
        rd_data_c = '0;
        case (reg_sel)
            REG_CTRL:   rd_data_c = {15'd0, enable_q};
            REG_STATUS: rd_data_c = status;
            REG_RXDATA: rd_data_c = rx_empty ? '0 : {8'd0, rx_head};
            REG_INTREQ: rd_data_c = intreq;
            REG_INTENA: rd_data_c = intena_q;
            REG_INTACT: rd_data_c = intact;
            REG_FILL:   rd_data_c = {8'd0, fill_q};
            default:    rd_data_c = '0;
        endcase
    end

    // CPU-visible registers; a sticky set in the same cycle as its clear wins
    always_ff @(posedge C100M) begin
        if (reset) begin
            enable_q    <= 1'b0;
            fill_q      <= FILL_RESET;
            intena_q    <= '0;
            underrun_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_end_q <= 1'b0;
            data_out    <= '0;
            MISO_oe     <= 1'b0;
            INT2_n      <= 1'b1;
        end else begin
            if (wr_strobe) begin
                case (reg_sel)
                    REG_CTRL:   enable_q <= data_in[0];
                    REG_INTENA: intena_q <= data_in;
                    REG_FILL:   fill_q   <= data_in[BYTE_W-1:0];
                    default:    ;
                endcase
            end
            underrun_q  <= (tx_load_c & tx_empty) | (underrun_q & ~intreq_clr[IR_UNDERRUN]);
            overrun_q   <= (rx_push_c & rx_full & ~rx_pop) | (overrun_q & ~intreq_clr[IR_OVERRUN]);
            frame_end_q <= frame_end_c | (frame_end_q & ~intreq_clr[IR_FRAME_END]);
            if (rd_strobe) data_out <= rd_data_c;
            MISO_oe <= enable_q & ss_active;
            INT2_n  <= ~(|intact);
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// Randomized scoreboard bench for spi_target against a queue-based model.
module tb_spi_target;
    import spi_target_pkg::*;

    logic        C100M, reset, access, RW, ds_n, SS_n, SCLK, MOSI;
    logic [23:1] ADDR;
    logic [15:0] data_in, data_out;
    logic        dtack_n, data_oe, INT2_n, MISO, MISO_oe;

    spi_target #(.FIFO_DEPTH(16), .FILL_RESET(8'hFF)) dut (
        .C100M(C100M), .reset(reset), .ADDR(ADDR), .access(access), .RW(RW),
        .ds_n(ds_n), .dtack_n(dtack_n), .data_oe(data_oe), .data_in(data_in),
        .data_out(data_out), .INT2_n(INT2_n), .SS_n(SS_n), .SCLK(SCLK),
        .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe)
    );

    initial C100M = 1'b0;
    always #5 C100M = ~C100M;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_rd_q[$];
    string       rd_tag_q[$];
    logic [4:0]  exp_pin_q[$];
    logic [4:0]  msk_pin_q[$];
    string       pin_tag_q[$];
    logic [7:0]  exp_miso_q[$];
    logic [7:0]  obs_miso_q[$];
    logic        rd_vld = 1'b0, pin_vld = 1'b0, done = 1'b0, flushed = 1'b0;

    // Reference model state
    logic [7:0]  tx_m[$];
    logic [7:0]  rx_m[$];
    logic        underrun_m, overrun_m, frame_end_m, enable_m;
    logic [7:0]  fill_m;
    logic [15:0] intena_m;
    logic [7:0]  mosi_buf [32];

    // Monitor: compares DUT outputs with queued expectations
    logic [15:0] mon_e16;
    logic [7:0]  mon_e8, mon_o8;
    logic [4:0]  mon_e5, mon_m5, mon_p5;
    string       mon_t;
    always @(negedge C100M) begin
        if (rd_vld) begin
            n_checks++;
            if (exp_rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected got=%h", data_out);
            end else begin
                mon_e16 = exp_rd_q.pop_front();
                mon_t   = rd_tag_q.pop_front();
                if (data_out !== mon_e16) begin
                    n_fail++;
                    $display("FAIL %s got=%h exp=%h", mon_t, data_out, mon_e16);
                end
            end
        end
        if (pin_vld) begin
            n_checks++;
            mon_e5 = exp_pin_q.pop_front();
            mon_m5 = msk_pin_q.pop_front();
            mon_t  = pin_tag_q.pop_front();
            mon_p5 = {MISO, MISO_oe, INT2_n, dtack_n, data_oe};
            if (((mon_p5 ^ mon_e5) & mon_m5) !== 5'd0) begin
                n_fail++;
                $display("FAIL %s pins{MISO,oe,INT2_n,dtack_n,data_oe} got=%b exp=%b mask=%b",
                         mon_t, mon_p5, mon_e5, mon_m5);
            end
        end
        while (obs_miso_q.size() > 0) begin
            n_checks++;
            mon_o8 = obs_miso_q.pop_front();
            if (exp_miso_q.size() == 0) begin
                n_fail++;
                $display("FAIL miso_unexpected got=%h", mon_o8);
            end else begin
                mon_e8 = exp_miso_q.pop_front();
                if (mon_o8 !== mon_e8) begin
                    n_fail++;
                    $display("FAIL miso_byte got=%h exp=%h", mon_o8, mon_e8);
                end
            end
        end
        if (done && !flushed) begin
            flushed = 1'b1;
            n_fail += exp_rd_q.size() + exp_pin_q.size() + exp_miso_q.size();
            if (exp_rd_q.size() + exp_pin_q.size() + exp_miso_q.size() != 0)
                $display("FAIL missing_outputs got=0 exp=%0d",
                         exp_rd_q.size() + exp_pin_q.size() + exp_miso_q.size());
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic void m_reset();
        tx_m.delete(); rx_m.delete();
        underrun_m = 0; overrun_m = 0; frame_end_m = 0; enable_m = 0;
        fill_m = 8'hFF; intena_m = '0;
    endfunction

    function automatic logic [15:0] m_status();
        return {9'd0, underrun_m, overrun_m, 1'b0, tx_m.size() == 16,
                tx_m.size() == 0, rx_m.size() == 16, rx_m.size() == 0};
    endfunction

    function automatic logic [15:0] m_intreq();
        return {12'd0, underrun_m, overrun_m, frame_end_m, rx_m.size() != 0};
    endfunction

    function automatic logic m_int2n();
        return ~(|(m_intreq() & intena_m));
    endfunction

    function automatic logic [7:0] m_load();
        if (tx_m.size() > 0) return tx_m.pop_front();
        underrun_m = 1'b1;
        return fill_m;
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] a);
        case (a)
            REG_CTRL:   return {15'd0, enable_m};
            REG_STATUS: return m_status();
            REG_RXDATA: return (rx_m.size() == 0) ? 16'd0 : {8'd0, rx_m.pop_front()};
            REG_INTREQ: return m_intreq();
            REG_INTENA: return intena_m;
            REG_INTACT: return m_intreq() & intena_m;
            REG_FILL:   return {8'd0, fill_m};
            default:    return 16'd0;
        endcase
    endfunction

    function automatic void m_write(input logic [2:0] a, input logic [15:0] d);
        case (a)
            REG_CTRL:   enable_m = d[0];
            REG_TXDATA: if (tx_m.size() < 16) tx_m.push_back(d[7:0]);
            REG_INTREQ: begin
                if (d[1]) frame_end_m = 0;
                if (d[2]) overrun_m   = 0;
                if (d[3]) underrun_m  = 0;
            end
            REG_INTENA: intena_m = d;
            REG_FILL:   fill_m = d[7:0];
            default: ;
        endcase
    endfunction

    task automatic check_pins(input logic [4:0] v, input logic [4:0] m, input string t);
        @(posedge C100M); #1;
        exp_pin_q.push_back(v); msk_pin_q.push_back(m); pin_tag_q.push_back(t);
        pin_vld = 1'b1;
        @(posedge C100M); #1;
        pin_vld = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        m_write(a, d);
        @(posedge C100M); #1;
        ADDR = {20'd0, a}; data_in = d; RW = 1'b0; access = 1'b1; ds_n = 1'b0;
        repeat (6) @(posedge C100M); #1;
        access = 1'b0; ds_n = 1'b1; RW = 1'b1;
        repeat (4) @(posedge C100M); #1;
    endtask

    task automatic rd(input logic [2:0] a, input string t);
        exp_rd_q.push_back(m_read(a)); rd_tag_q.push_back(t);
        @(posedge C100M); #1;
        ADDR = {20'd0, a}; RW = 1'b1; access = 1'b1; ds_n = 1'b0;
        repeat (5) @(posedge C100M); #1;
        check_pins({2'b00, m_int2n(), 2'b01}, 5'b00111, {t, "_bus"});
        access = 1'b0; ds_n = 1'b1;
        repeat (3) @(posedge C100M); #1;
        rd_vld = 1'b1;
        @(posedge C100M); #1;
        rd_vld = 1'b0;
    endtask

    // Master side of a mode-0 frame; MISO captured just before each rising edge
    task automatic frame(input int nbits);
        logic [7:0] ld, cap;
        ld = m_load();
        for (int b = 0; b < nbits / 8; b++) begin
            exp_miso_q.push_back(ld);
            if (rx_m.size() < 16) rx_m.push_back(mosi_buf[b]);
            else overrun_m = 1'b1;
            ld = m_load();
        end
        frame_end_m = 1'b1;
        cap = '0;
        SS_n = 1'b0; #300;
        for (int k = 0; k < nbits; k++) begin
            MOSI = mosi_buf[k / 8][7 - (k % 8)];
            #50;
            cap = {cap[6:0], MISO};
            SCLK = 1'b1; #50; SCLK = 1'b0;
            if (k % 8 == 7) obs_miso_q.push_back(cap);
        end
        #100; SS_n = 1'b1; #300;
    endtask

    task automatic drain(input string t);
        int n;
        n = rx_m.size();
        for (int i = 0; i <= n; i++) rd(REG_RXDATA, t);
    endtask

    initial begin
        reset = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0; access = 1'b0;
        ds_n = 1'b1; RW = 1'b1; ADDR = '0; data_in = '0;
        m_reset();
        repeat (5) @(posedge C100M); #1;
        exp_rd_q.push_back(16'h0000); rd_tag_q.push_back("data_out_reset");
        rd_vld = 1'b1; @(posedge C100M); #1; rd_vld = 1'b0;
        check_pins(5'b10110, 5'b11111, "pins_reset");
        reset = 1'b0;
        repeat (3) @(posedge C100M); #1;
        rd(REG_STATUS, "status_reset");
        rd(REG_FILL, "fill_reset");
        rd(REG_CTRL, "ctrl_reset");

        // Two queued bytes out, two bytes in
        wr(REG_CTRL, 16'h0001);
        wr(REG_TXDATA, 16'h00A5);
        wr(REG_TXDATA, 16'h003C);
        mosi_buf[0] = 8'h81; mosi_buf[1] = 8'h7E;
        frame(16);
        rd(REG_RXDATA, "rx_byte0");
        rd(REG_RXDATA, "rx_byte1");
        rd(REG_STATUS, "status_after_basic");
        wr(REG_INTREQ, 16'h000E);

        // Underrun sends FILL
        wr(REG_FILL, 16'h005A);
        mosi_buf[0] = 8'($urandom);
        frame(8);
        rd(REG_STATUS, "status_underrun");
        rd(REG_INTREQ, "intreq_underrun");
        wr(REG_INTREQ, 16'h0008);
        rd(REG_INTREQ, "intreq_underrun_cleared");
        drain("rx_fill_frame");
        wr(REG_INTREQ, 16'h000E);

        // RX overrun with 17 bytes
        wr(REG_FILL, 16'($urandom_range(0, 255)));
        for (int i = 0; i < 17; i++) mosi_buf[i] = 8'($urandom);
        frame(17 * 8);
        rd(REG_STATUS, "status_rx_overrun");
        drain("rx_overrun_data");
        rd(REG_STATUS, "status_rx_drained");
        wr(REG_INTREQ, 16'h000E);

        // TX overflow: 17th write lost, frame shows 16 then FILL
        for (int i = 0; i < 17; i++) wr(REG_TXDATA, 16'($urandom));
        rd(REG_STATUS, "status_tx_full");
        for (int i = 0; i < 17; i++) mosi_buf[i] = 8'($urandom);
        frame(17 * 8);
        drain("rx_tx_full_frame");
        rd(REG_STATUS, "status_tx_frame");
        wr(REG_INTREQ, 16'h000E);

        // Random traffic
        for (int it = 0; it < 6; it++) begin
            int np, nb;
            np = int'($urandom_range(0, 3));
            nb = int'($urandom_range(1, 24));
            for (int i = 0; i < np; i++) wr(REG_TXDATA, 16'($urandom));
            if ($urandom_range(0, 1) == 1) wr(REG_FILL, 16'($urandom_range(0, 255)));
            for (int i = 0; i < 3; i++) mosi_buf[i] = 8'($urandom);
            frame(nb);
            rd(REG_STATUS, "rand_status");
            rd(REG_INTREQ, "rand_intreq");
            drain("rand_rx");
            wr(REG_INTREQ, 16'h000E);
        end

        // Short frame: partial byte dropped, frame_end raised
        frame(5);
        rd(REG_STATUS, "status_partial");
        rd(REG_INTREQ, "intreq_partial");
        wr(REG_INTENA, 16'h0002);
        check_pins({2'b00, m_int2n(), 2'b10}, 5'b00111, "int2_frame_end");
        rd(REG_INTACT, "intact_frame_end");
        rd(REG_INTENA, "intena_readback");

        // Reset in the middle of a byte
        SS_n = 1'b0; #300;
        for (int k = 0; k < 3; k++) begin
            MOSI = k[0]; #50; SCLK = 1'b1; #50; SCLK = 1'b0;
        end
        #100;
        check_pins({2'b01, m_int2n(), 2'b10}, 5'b01111, "pins_mid_frame");
        @(posedge C100M); #1;
        reset = 1'b1;
        m_reset();
        @(posedge C100M); #1;
        check_pins(5'b10110, 5'b11111, "pins_mid_frame_reset");
        reset = 1'b0;
        SS_n = 1'b1; #300;
        rd(REG_STATUS, "status_after_abort");
        rd(REG_INTREQ, "intreq_after_abort");
        rd(REG_CTRL, "ctrl_after_abort");

        done = 1'b1;
        repeat (3) @(posedge C100M);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 C100M  in  1  system clock, 100 MHz; sole clock.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 ADDR[23:1] in 23 CPU address; ADDR[3:1] selects register. access in 1 chip select; RW in 1 (1=read); ds_n in 1 data strobe, active low.
REQ-004 dtack_n out 1 = !access; data_oe out 1 = access & !ds_n & RW.
REQ-005 data_in in 16 CPU write data; data_out out 16 registered read data.
REQ-006 INT2_n out 1 interrupt, active low = !(|INTACT).
REQ-007 SS_n in 1 / SCLK in 1 / MOSI in 1: external SPI master pins, asynchronous.
REQ-008 MISO out 1 serial output; MISO_oe out 1 = enable & SS active (synced).
REQ-009 Params: FIFO_DEPTH default 16 (RX and TX each, power of 2); FILL_RESET default 8'hFF.

Function
REQ-010 Bus strobes: wr/rd access each through 3-flop sync; strobe on sync[2:1]==01; one action per access.
REQ-011 Register map ADDR[3:1]: 0 CTRL (bit0 enable); 1 STATUS (RO); 2 RXDATA (RO, read pops); 3 TXDATA (WO, write pushes data_in[7:0]); 4 INTREQ; 5 INTENA; 6 INTACT (RO); 7 FILL [7:0].
REQ-012 STATUS = {9'd0, underrun, overrun, ss_active, tx_full, tx_empty, rx_full, rx_empty}.
REQ-013 data_out latched on rd_strobe; RXDATA read when empty returns 16'd0, no pop.
REQ-014 TXDATA write when tx_full: dropped, FIFO unchanged.
REQ-015 SS_n, SCLK, MOSI each 3-flop synchronized; edges detected on stages [2:1]; max SCLK = 12.5 MHz.
REQ-016 SPI mode 0 only: MOSI sampled on synced SCLK rising edge, MSB first.
REQ-017 States IDLE, ACTIVE. IDLE->ACTIVE on SS falling edge with enable=1: bit_cnt=0, tx_shift loaded.
REQ-018 ACTIVE rising edge: rx_shift <= {rx_shift[6:0], MOSI}, bit_cnt+1 (3-bit, wraps).
REQ-019 bit_cnt wrap 7->0: push byte to RX FIFO, reload tx_shift same cycle.
REQ-020 ACTIVE falling edge with bit_cnt!=0: tx_shift shifts left; bit_cnt==0: no shift. MISO = tx_shift[7].
REQ-021 tx_shift load: TX FIFO head (pop) if not empty; else FILL and set underrun sticky.
REQ-022 RX push when rx_full and no same-cycle pop: byte dropped, overrun sticky set; full with same-cycle pop: push accepted.
REQ-023 ACTIVE->IDLE on SS rising edge or enable=0: partial byte discarded, bit_cnt=0, frame_end sticky set (SS edge only).
REQ-024 INTREQ = {12'd0, underrun, overrun, frame_end, !rx_empty}; write 1 to bits[3:1] clears; bit0 level only. Set and clear same cycle: set wins.
REQ-025 INTENA 16-bit R/W; INTACT = INTREQ & INTENA.
REQ-026 FIFOs: count 0..FIFO_DEPTH, pointers wrap modulo depth; simultaneous push/pop when empty on TX: CPU push accepted, SPI load sees FIFO empty (FILL).

Reset
REQ-027 reset: state IDLE, CTRL=0, INTENA=0, stickies 0, FIFOs empty, FILL=FILL_RESET, tx_shift=8'hFF, bit_cnt=0, data_out=0.
REQ-028 Outputs under reset: MISO=1, MISO_oe=0, INT2_n=1; reset mid-frame aborts without frame_end.

Structure
REQ-029 Register address localparams and STATUS/INTREQ bit indices in shared package spi_target_pkg.
REQ-030 One sub-module sync_fifo (8-bit, FIFO_DEPTH, push/pop/full/empty/count), instantiated for RX and TX.

Verification
REQ-031 Enable, push A5,3C; master sends 2 bytes 81,7E at 10 MHz -> MISO carries A5,3C; RXDATA reads 0081,007E; tx_empty=1.
REQ-032 TX empty, FILL=5A, 1-byte frame -> MISO 5A, STATUS underrun=1, INTREQ bit3=1; write INTREQ=0008 -> cleared.
REQ-033 17 bytes, no CPU reads -> 16 stored, rx_full=1, overrun=1; reads return bytes 1..16 in order.
REQ-034 SS_n deasserted after 5 SCLKs -> no RX push, frame_end=1; INTENA=0002 -> INT2_n=0; INTACT=0002.
REQ-035 reset asserted mid-byte -> next cycle state IDLE, MISO_oe=0, INTREQ=0, FIFOs empty.
REQ-036 TXDATA writes x17 -> first 16 kept, tx_full=1, 17th lost.
